// File: rtl/dmem_io_sequencer_if.sv
// rtl/dmem_io_sequencer_if.sv - CPU, loader, BRAM and IO bus signals of the data-memory/IO sequencer
interface dmem_io_sequencer_if;
    // CPU side
    logic        cpu_mem_rd;
    logic        cpu_mem_wr;
    logic        cpu_io_rd;
    logic        cpu_io_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // program loader side
    logic        ld_req;
    logic [13:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_grant;
    // data BRAM side
    logic        mem_en;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // IO bus side
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic        io_err;

    modport slave (
        input  cpu_mem_rd, cpu_mem_wr, cpu_io_rd, cpu_io_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ld_req, ld_addr, ld_wdata,
        output ld_grant,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_rdata,
        output io_err
    );

    modport master (
        output cpu_mem_rd, cpu_mem_wr, cpu_io_rd, cpu_io_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ld_req, ld_addr, ld_wdata,
        input  ld_grant,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_rdata,
        input  io_err
    );
endinterface

// File: rtl/dmem_io_sequencer.sv
// rtl/dmem_io_sequencer.sv - data BRAM / IO access sequencer with loader arbitration; optional IO_TIMEOUT_EN
module dmem_io_sequencer (
    input  logic                        clk,
    input  logic                        rst_n,
    dmem_io_sequencer_if.slave          bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEM_RD  = 2'd1;
    localparam logic [1:0] S_IO_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_data;
    logic [7:0]  r_io_addr;
    logic [31:0] r_io_wdata;
    logic        r_io_we;
    logic        r_io_err;

    logic [1:0]  w_next_state;
    logic        w_latch;
    logic        w_stall;
    logic        w_mem_en;
    logic        w_mem_we;
    logic [13:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_ld_grant;
    logic        w_any_strobe;
    logic        w_timeout;
    logic        w_io_req;

    // Address bits outside the BRAM word index and IO offset are don't-care.
    logic        w_unused;
    assign w_unused = &{1'b0, bus.cpu_addr[31:16], bus.cpu_addr[1:0]};

    assign w_any_strobe = bus.cpu_mem_rd | bus.cpu_mem_wr | bus.cpu_io_rd | bus.cpu_io_wr;
    assign w_io_req     = (r_state == S_IO_WAIT);

`ifdef IO_TIMEOUT_EN
    logic [3:0] r_to_cnt;

    assign w_timeout = w_io_req && !bus.io_ack && (r_to_cnt == 4'hF);

    // Count consecutive un-acked IO_WAIT cycles; flag a timeout stickily until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= 4'd0;
            r_io_err <= 1'b0;
        end else begin
            if (w_io_req && !bus.io_ack) begin
                r_to_cnt <= r_to_cnt + 4'd1;
            end else begin
                r_to_cnt <= 4'd0;
            end
            if (w_timeout) begin
                r_io_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign r_io_err  = 1'b0;
`endif

    // Next-state, loader/store arbitration and BRAM drive for the current cycle.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_stall      = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = 14'd0;
        w_mem_wdata  = 32'd0;
        w_ld_grant   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ld_req) begin
                    // Loader owns the BRAM this cycle; any CPU access retries next cycle.
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = bus.ld_addr;
                    w_mem_wdata = bus.ld_wdata;
                    w_ld_grant  = 1'b1;
                    w_stall     = w_any_strobe;
                end else if (bus.cpu_io_wr || bus.cpu_io_rd) begin
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_next_state = S_IO_WAIT;
                end else if (bus.cpu_mem_wr) begin
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = bus.cpu_addr[15:2];
                    w_mem_wdata = bus.cpu_wdata;
                end else if (bus.cpu_mem_rd) begin
                    w_mem_en     = 1'b1;
                    w_mem_addr   = bus.cpu_addr[15:2];
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_next_state = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                w_stall      = 1'b1;
                w_next_state = S_DONE;
            end
            S_IO_WAIT: begin
                w_stall = 1'b1;
                if (bus.io_ack || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, access latch and load-data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= 32'd0;
            r_io_addr  <= 8'd0;
            r_io_wdata <= 32'd0;
            r_io_we    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_io_addr  <= bus.cpu_addr[7:0];
                r_io_wdata <= bus.cpu_wdata;
                r_io_we    <= bus.cpu_io_wr;
            end
            if (r_state == S_MEM_RD) begin
                r_data <= bus.mem_rdata;
            end else if (w_io_req && bus.io_ack) begin
                if (!r_io_we) begin
                    r_data <= bus.io_rdata;
                end
            end else if (w_timeout) begin
                r_data <= 32'd0;
            end
        end
    end

    // Every output is forced low while reset is held, aborting any IO access at once.
    assign bus.cpu_stall = rst_n & w_stall;
    assign bus.cpu_rdata = rst_n ? r_data : 32'd0;
    assign bus.ld_grant  = rst_n & w_ld_grant;
    assign bus.mem_en    = rst_n & w_mem_en;
    assign bus.mem_we    = rst_n & w_mem_we;
    assign bus.mem_addr  = rst_n ? w_mem_addr : 14'd0;
    assign bus.mem_wdata = rst_n ? w_mem_wdata : 32'd0;
    assign bus.io_req    = rst_n & w_io_req;
    assign bus.io_we     = rst_n & w_io_req & r_io_we;
    assign bus.io_addr   = (rst_n && w_io_req) ? r_io_addr : 8'd0;
    assign bus.io_wdata  = (rst_n && w_io_req) ? r_io_wdata : 32'd0;
    assign bus.io_err    = rst_n & r_io_err;
endmodule

// File: tb/tb_dmem_io_sequencer.sv
// tb/tb_dmem_io_sequencer.sv - directed self-checking bench for dmem_io_sequencer
module tb_dmem_io_sequencer;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    dmem_io_sequencer_if bus ();

    dmem_io_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.cpu_mem_rd = 1'b0;
        bus.cpu_mem_wr = 1'b0;
        bus.cpu_io_rd  = 1'b0;
        bus.cpu_io_wr  = 1'b0;
        bus.cpu_addr   = 32'd0;
        bus.cpu_wdata  = 32'd0;
        bus.ld_req     = 1'b0;
        bus.ld_addr    = 14'd0;
        bus.ld_wdata   = 32'd0;
        bus.mem_rdata  = 32'd0;
        bus.io_ack     = 1'b0;
        bus.io_rdata   = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cpu_mem_rd = 1'b1;
        bus.cpu_io_rd  = 1'b1;
        bus.ld_req     = 1'b1;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got=%0h exp=0", bus.mem_en); else n_pass++;
        n_total++; if (bus.ld_grant !== 1'b0) $display("FAIL rst_ld_grant got=%0h exp=0", bus.ld_grant); else n_pass++;
        n_total++; if (bus.io_req !== 1'b0) $display("FAIL rst_io_req got=%0h exp=0", bus.io_req); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'd0) $display("FAIL rst_rdata got=%0h exp=0", bus.cpu_rdata); else n_pass++;
        n_total++; if (bus.io_err !== 1'b0) $display("FAIL rst_io_err got=%0h exp=0", bus.io_err); else n_pass++;
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL idle_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        next_cycle();
    endtask

    task automatic test_mem_load;
        bus.cpu_addr   = 32'h0000_0010;
        bus.cpu_mem_rd = 1'b1;
        @(negedge clk);
        n_total++; if (bus.mem_en !== 1'b1) $display("FAIL ld_mem_en got=%0h exp=1", bus.mem_en); else n_pass++;
        n_total++; if (bus.mem_we !== 1'b0) $display("FAIL ld_mem_we got=%0h exp=0", bus.mem_we); else n_pass++;
        n_total++; if (bus.mem_addr !== 14'd4) $display("FAIL ld_mem_addr got=%0h exp=4", bus.mem_addr); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL ld_stall0 got=%0h exp=1", bus.cpu_stall); else n_pass++;
        next_cycle();
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL ld_stall1 got=%0h exp=1", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.mem_en !== 1'b0) $display("FAIL ld_mem_en1 got=%0h exp=0", bus.mem_en); else n_pass++;
        next_cycle();
        bus.cpu_mem_rd = 1'b0;
        bus.mem_rdata  = 32'd0;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL ld_done_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL ld_rdata got=%0h exp=deadbeef", bus.cpu_rdata); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL ld_rdata_hold got=%0h exp=deadbeef", bus.cpu_rdata); else n_pass++;
        next_cycle();
    endtask

    task automatic test_store;
        bus.cpu_addr   = 32'h0000_0024;
        bus.cpu_wdata  = 32'h1122_3344;
        bus.cpu_mem_wr = 1'b1;
        @(negedge clk);
        n_total++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) $display("FAIL st_en_we got=%0h%0h exp=11", bus.mem_en, bus.mem_we); else n_pass++;
        n_total++; if (bus.mem_addr !== 14'd9) $display("FAIL st_addr got=%0h exp=9", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 32'h1122_3344) $display("FAIL st_wdata got=%0h exp=11223344", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL st_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_loader_conflict;
        bus.cpu_addr   = 32'h0000_0040;
        bus.cpu_wdata  = 32'hAAAA_0001;
        bus.cpu_mem_wr = 1'b1;
        bus.ld_req     = 1'b1;
        bus.ld_addr    = 14'h0123;
        bus.ld_wdata   = 32'hBBBB_0002;
        @(negedge clk);
        n_total++; if (bus.ld_grant !== 1'b1) $display("FAIL lc_grant got=%0h exp=1", bus.ld_grant); else n_pass++;
        n_total++; if (bus.mem_addr !== 14'h0123) $display("FAIL lc_addr got=%0h exp=123", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 32'hBBBB_0002) $display("FAIL lc_wdata got=%0h exp=bbbb0002", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.mem_we !== 1'b1) $display("FAIL lc_we got=%0h exp=1", bus.mem_we); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL lc_stall got=%0h exp=1", bus.cpu_stall); else n_pass++;
        next_cycle();
        bus.ld_req = 1'b0;
        @(negedge clk);
        n_total++; if (bus.mem_addr !== 14'h0010) $display("FAIL lc_cpu_addr got=%0h exp=10", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 32'hAAAA_0001) $display("FAIL lc_cpu_wdata got=%0h exp=aaaa0001", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL lc_cpu_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.ld_grant !== 1'b0) $display("FAIL lc_grant2 got=%0h exp=0", bus.ld_grant); else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_io_read;
        int stalls;
        stalls = 0;
        bus.cpu_addr  = 32'hFFFF_FC60;
        bus.cpu_io_rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 1 && i <= 3) begin
                bus.ld_req   = 1'b1;
                bus.ld_addr  = 14'h0055;
                bus.ld_wdata = 32'h1234_5678;
            end else begin
                bus.ld_req = 1'b0;
            end
            bus.io_ack   = (i == 4);
            bus.io_rdata = (i == 4) ? 32'h0000_005A : 32'h0000_00EE;
            if (i == 5) bus.cpu_io_rd = 1'b0;
            @(negedge clk);
            if (bus.cpu_stall === 1'b1) stalls++;
            if (i == 0) begin
                n_total++; if (bus.io_req !== 1'b0) $display("FAIL ior_req0 got=%0h exp=0", bus.io_req); else n_pass++;
            end
            if (i == 1) begin
                n_total++; if (bus.io_req !== 1'b1) $display("FAIL ior_req1 got=%0h exp=1", bus.io_req); else n_pass++;
                n_total++; if (bus.io_addr !== 8'h60) $display("FAIL ior_addr got=%0h exp=60", bus.io_addr); else n_pass++;
                n_total++; if (bus.io_we !== 1'b0) $display("FAIL ior_we got=%0h exp=0", bus.io_we); else n_pass++;
                n_total++; if (bus.ld_grant !== 1'b0) $display("FAIL ior_ld_grant got=%0h exp=0", bus.ld_grant); else n_pass++;
                n_total++; if (bus.mem_en !== 1'b0) $display("FAIL ior_mem_en got=%0h exp=0", bus.mem_en); else n_pass++;
            end
            if (i == 4) begin
                n_total++; if (bus.io_req !== 1'b1) $display("FAIL ior_req4 got=%0h exp=1", bus.io_req); else n_pass++;
            end
            if (i == 5) begin
                n_total++; if (bus.io_req !== 1'b0) $display("FAIL ior_req5 got=%0h exp=0", bus.io_req); else n_pass++;
                n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL ior_done_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
                n_total++; if (bus.cpu_rdata !== 32'h0000_005A) $display("FAIL ior_rdata got=%0h exp=5a", bus.cpu_rdata); else n_pass++;
            end
            next_cycle();
        end
        n_total++; if (stalls != 5) $display("FAIL ior_stall_count got=%0d exp=5", stalls); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_io_write;
        bus.cpu_addr   = 32'h0000_0084;
        bus.cpu_wdata  = 32'hCAFE_F00D;
        bus.cpu_io_wr  = 1'b1;
        bus.cpu_mem_rd = 1'b1;
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b1) $display("FAIL iow_stall got=%0h exp=1", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.mem_en !== 1'b0) $display("FAIL iow_prio_mem_en got=%0h exp=0", bus.mem_en); else n_pass++;
        next_cycle();
        bus.cpu_addr  = 32'h0000_0000;
        bus.cpu_wdata = 32'h0000_0000;
        bus.io_ack    = 1'b1;
        bus.io_rdata  = 32'h0000_0077;
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b1 || bus.io_we !== 1'b1) $display("FAIL iow_req_we got=%0h%0h exp=11", bus.io_req, bus.io_we); else n_pass++;
        n_total++; if (bus.io_addr !== 8'h84) $display("FAIL iow_addr got=%0h exp=84", bus.io_addr); else n_pass++;
        n_total++; if (bus.io_wdata !== 32'hCAFE_F00D) $display("FAIL iow_wdata got=%0h exp=cafef00d", bus.io_wdata); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_total++; if (bus.cpu_stall !== 1'b0 || bus.io_req !== 1'b0) $display("FAIL iow_done got=%0h%0h exp=00", bus.cpu_stall, bus.io_req); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'h0000_005A) $display("FAIL iow_rdata_kept got=%0h exp=5a", bus.cpu_rdata); else n_pass++;
        next_cycle();
    endtask

    task automatic test_ack_ignored;
        bus.io_ack   = 1'b1;
        bus.io_rdata = 32'h0000_0099;
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b0 || bus.cpu_stall !== 1'b0) $display("FAIL ack_idle got=%0h%0h exp=00", bus.io_req, bus.cpu_stall); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_total++; if (bus.cpu_rdata !== 32'h0000_005A) $display("FAIL ack_idle_rdata got=%0h exp=5a", bus.cpu_rdata); else n_pass++;
        next_cycle();
    endtask

    task automatic test_io_timeout;
        int hi;
        bit done;
        hi   = 0;
        done = 1'b0;
        bus.cpu_addr  = 32'h0000_0008;
        bus.cpu_wdata = 32'h0000_0001;
        bus.cpu_io_wr = 1'b1;
        next_cycle();
`ifdef IO_TIMEOUT_EN
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.io_req === 1'b1) begin
                hi++;
                next_cycle();
            end else begin
                done = 1'b1;
                bus.cpu_io_wr = 1'b0;
            end
        end
        n_total++; if (!done) $display("FAIL to_bound got=running exp=done"); else n_pass++;
        n_total++; if (hi != 16) $display("FAIL to_req_cycles got=%0d exp=16", hi); else n_pass++;
        n_total++; if (bus.io_err !== 1'b1) $display("FAIL to_err got=%0h exp=1", bus.io_err); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'd0) $display("FAIL to_rdata got=%0h exp=0", bus.cpu_rdata); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL to_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_total++; if (bus.io_err !== 1'b1) $display("FAIL to_err_sticky got=%0h exp=1", bus.io_err); else n_pass++;
        n_total++; if (bus.io_req !== 1'b0 || bus.cpu_stall !== 1'b0) $display("FAIL to_idle got=%0h%0h exp=00", bus.io_req, bus.cpu_stall); else n_pass++;
        next_cycle();
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.io_req === 1'b1) hi++;
            next_cycle();
        end
        n_total++; if (hi != 20) $display("FAIL nt_req_cycles got=%0d exp=20", hi); else n_pass++;
        n_total++; if (bus.io_err !== 1'b0) $display("FAIL nt_err got=%0h exp=0", bus.io_err); else n_pass++;
        bus.io_ack = 1'b1;
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b1) $display("FAIL nt_req_at_ack got=%0h exp=1", bus.io_req); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b0 || bus.cpu_stall !== 1'b0) $display("FAIL nt_done got=%0h%0h exp=00", bus.io_req, bus.cpu_stall); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'h0000_005A) $display("FAIL nt_rdata got=%0h exp=5a", bus.cpu_rdata); else n_pass++;
        next_cycle();
`endif
    endtask

    task automatic test_reset_mid_io;
        bus.cpu_addr  = 32'h0000_0010;
        bus.cpu_io_rd = 1'b1;
        next_cycle();
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b1) $display("FAIL rmi_req_pre got=%0h exp=1", bus.io_req); else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b0 || bus.cpu_stall !== 1'b0) $display("FAIL rmi_in_reset got=%0h%0h exp=00", bus.io_req, bus.cpu_stall); else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        bus.cpu_io_rd = 1'b0;
        bus.io_ack    = 1'b1;
        bus.io_rdata  = 32'h0000_0033;
        @(negedge clk);
        n_total++; if (bus.io_req !== 1'b0) $display("FAIL rmi_req got=%0h exp=0", bus.io_req); else n_pass++;
        n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL rmi_stall got=%0h exp=0", bus.cpu_stall); else n_pass++;
        n_total++; if (bus.io_err !== 1'b0) $display("FAIL rmi_err got=%0h exp=0", bus.io_err); else n_pass++;
        next_cycle();
        bus.io_ack     = 1'b0;
        bus.cpu_addr   = 32'h0000_0008;
        bus.cpu_wdata  = 32'h0000_0005;
        bus.cpu_mem_wr = 1'b1;
        @(negedge clk);
        n_total++; if (bus.mem_en !== 1'b1 || bus.cpu_stall !== 1'b0) $display("FAIL rmi_idle_store got=%0h%0h exp=10", bus.mem_en, bus.cpu_stall); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 32'd0) $display("FAIL rmi_late_ack_rdata got=%0h exp=0", bus.cpu_rdata); else n_pass++;
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        n_pass  = 0;
        n_total = 0;
        clear_inputs();
        #1;
        test_reset();
        test_mem_load();
        test_store();
        test_loader_conflict();
        test_io_read();
        test_io_write();
        test_ack_ignored();
        test_io_timeout();
        test_reset_mid_io();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
